// File: rtl/digit_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial add/subtract unit.
// master: requester (drives start/sub/a/b); slave: the arithmetic unit.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit: LSB-first, DIGIT bits per clock through a
// DIGIT-long ripple of full-adder cells. Subtraction is a + ~b + 1, with the
// +1 injected as the initial carry. Carry, signed overflow and zero flags are
// taken from the final digit and held until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold the last operation
// RUN   | one digit per clock, NDIG clocks, then done pulse and back to IDLE
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_addsub_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: WIDTH must be >=2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] sum_dig;
  logic [WIDTH-1:0] result_shift;
  logic             last_dig;

  // Ripple of DIGIT full-adder cells over the low digit of the operand regs
  always_comb begin
    chain    = '0;
    sum_dig  = '0;
    chain[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum_dig[i]   = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New digit enters at the MSB end; after NDIG shifts the result is aligned
  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign result_shift = sum_dig;
    end else begin : g_multi_digit
      assign result_shift = {sum_dig, result_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // Next-state and datapath update for the IDLE/RUN sequencer
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        carry_d  = chain[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        result_d = result_shift;
        if (last_dig) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          zero_d  = (result_shift == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async active-low reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT=4, 1, 32) share one
// stimulus; outputs are compared against a plain-arithmetic reference model.
module tb_digit_serial_addsub;

  localparam int W  = 32;
  localparam int NT = 3;
  localparam int LAT_T [NT] = '{8, 32, 1};

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_serial_addsub_if #(.WIDTH(W)) bus_d4  ();
  digit_serial_addsub_if #(.WIDTH(W)) bus_d1  ();
  digit_serial_addsub_if #(.WIDTH(W)) bus_d32 ();

  assign bus_d4.start  = start;  assign bus_d4.sub  = sub;  assign bus_d4.a  = a;  assign bus_d4.b  = b;
  assign bus_d1.start  = start;  assign bus_d1.sub  = sub;  assign bus_d1.a  = a;  assign bus_d1.b  = b;
  assign bus_d32.start = start;  assign bus_d32.sub = sub;  assign bus_d32.a = a;  assign bus_d32.b = b;

  digit_serial_addsub #(.WIDTH(W), .DIGIT(4))  u_dut_d4  (.clk(clk), .rst(rst), .bus(bus_d4));
  digit_serial_addsub #(.WIDTH(W), .DIGIT(1))  u_dut_d1  (.clk(clk), .rst(rst), .bus(bus_d1));
  digit_serial_addsub #(.WIDTH(W), .DIGIT(32)) u_dut_d32 (.clk(clk), .rst(rst), .bus(bus_d32));

  logic         done_v   [NT];
  logic         busy_v   [NT];
  logic         cout_v   [NT];
  logic         ovf_v    [NT];
  logic         zero_v   [NT];
  logic [W-1:0] result_v [NT];

  assign done_v[0] = bus_d4.done;  assign done_v[1] = bus_d1.done;  assign done_v[2] = bus_d32.done;
  assign busy_v[0] = bus_d4.busy;  assign busy_v[1] = bus_d1.busy;  assign busy_v[2] = bus_d32.busy;
  assign cout_v[0] = bus_d4.cout;  assign cout_v[1] = bus_d1.cout;  assign cout_v[2] = bus_d32.cout;
  assign ovf_v[0]  = bus_d4.ovf;   assign ovf_v[1]  = bus_d1.ovf;   assign ovf_v[2]  = bus_d32.ovf;
  assign zero_v[0] = bus_d4.zero;  assign zero_v[1] = bus_d1.zero;  assign zero_v[2] = bus_d32.zero;
  assign result_v[0] = bus_d4.result;
  assign result_v[1] = bus_d1.result;
  assign result_v[2] = bus_d32.result;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus textbook flag definitions
  function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic [W-1:0] r, output logic c, output logic o,
                                    output logic z);
    logic [W:0] full;
    if (s) begin
      full = {1'b0, x} - {1'b0, y};
      r    = full[W-1:0];
      c    = (x >= y);
      o    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      c    = full[W];
      o    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    z = (r == '0);
  endfunction

  // One operation on all three instances; optional scrambling of inputs while busy
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic ts, input bit scramble,
                       output logic [W-1:0] r0, output logic c0, output logic o0, output logic z0);
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat   [NT];
    int           ndone [NT];
    int           nbusy [NT];
    logic [W-1:0] cap_r [NT];
    logic         cap_c [NT];
    logic         cap_o [NT];
    logic         cap_z [NT];
    ref_model(ta, tb_, ts, er, ec, eo, ez);
    for (int k = 0; k < NT; k++) begin
      lat[k] = -1; ndone[k] = 0; nbusy[k] = 0;
      cap_r[k] = '0; cap_c[k] = 1'b0; cap_o[k] = 1'b0; cap_z[k] = 1'b0;
    end
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    for (int n = 0; n <= 34; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        start = 1'b0;
        if (scramble) begin
          a = $urandom; b = $urandom; sub = 1'($urandom);
        end
      end
      for (int k = 0; k < NT; k++) begin
        if (busy_v[k]) nbusy[k]++;
        if (done_v[k]) begin
          ndone[k]++;
          if (lat[k] < 0) begin
            lat[k]   = n;
            cap_r[k] = result_v[k];
            cap_c[k] = cout_v[k];
            cap_o[k] = ovf_v[k];
            cap_z[k] = zero_v[k];
            check($sformatf("%s_k%0d_busy_at_done", name, k), 64'(busy_v[k]), 64'(0));
          end
        end
      end
    end
    for (int k = 0; k < NT; k++) begin
      check($sformatf("%s_k%0d_done_pulses", name, k), 64'(ndone[k]), 64'(1));
      check($sformatf("%s_k%0d_latency", name, k), 64'(lat[k]), 64'(LAT_T[k]));
      check($sformatf("%s_k%0d_busy_cycles", name, k), 64'(nbusy[k]), 64'(LAT_T[k]));
      if (lat[k] >= 0) begin
        check($sformatf("%s_k%0d_result", name, k), 64'(cap_r[k]), 64'(er));
        check($sformatf("%s_k%0d_cout", name, k), 64'(cap_c[k]), 64'(ec));
        check($sformatf("%s_k%0d_ovf", name, k), 64'(cap_o[k]), 64'(eo));
        check($sformatf("%s_k%0d_zero", name, k), 64'(cap_z[k]), 64'(ez));
      end
    end
    r0 = cap_r[0]; c0 = cap_c[0]; o0 = cap_o[0]; z0 = cap_z[0];
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom % 8)
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    logic         c, o, z;
    int           phase, t1, lat1, lat2, nd;

    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    for (int k = 0; k < NT; k++) begin
      check($sformatf("rst_k%0d_busy", k), 64'(busy_v[k]), 64'(0));
      check($sformatf("rst_k%0d_done", k), 64'(done_v[k]), 64'(0));
      check($sformatf("rst_k%0d_result", k), 64'(result_v[k]), 64'(0));
      check($sformatf("rst_k%0d_flags", k), 64'({cout_v[k], ovf_v[k], zero_v[k]}), 64'(0));
    end
    @(negedge clk); rst = 1'b1;

    do_op("t1_add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, c, o, z);
    check("t1_result", 64'(r), 64'(32'h0)); check("t1_cout", 64'(c), 64'(1));
    check("t1_ovf", 64'(o), 64'(0));        check("t1_zero", 64'(z), 64'(1));

    do_op("t2_sub_neg", 32'd5, 32'd7, 1'b1, 1'b0, r, c, o, z);
    check("t2a_result", 64'(r), 64'(32'hFFFF_FFFE)); check("t2a_cout", 64'(c), 64'(0));
    check("t2a_ovf", 64'(o), 64'(0));                check("t2a_zero", 64'(z), 64'(0));
    do_op("t2_sub_eq", 32'd7, 32'd7, 1'b1, 1'b0, r, c, o, z);
    check("t2b_result", 64'(r), 64'(32'h0)); check("t2b_cout", 64'(c), 64'(1));
    check("t2b_zero", 64'(z), 64'(1));

    do_op("t3_add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, r, c, o, z);
    check("t3a_result", 64'(r), 64'(32'h8000_0000)); check("t3a_ovf", 64'(o), 64'(1));
    check("t3a_cout", 64'(c), 64'(0));
    do_op("t3_sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0, r, c, o, z);
    check("t3b_result", 64'(r), 64'(32'h7FFF_FFFF)); check("t3b_ovf", 64'(o), 64'(1));
    check("t3b_cout", 64'(c), 64'(1));

    // start pulses while busy are ignored; start in the done cycle is accepted
    phase = 0; t1 = 0; lat1 = -1; lat2 = -1;
    @(negedge clk);
    a = 32'd100; b = 32'd23; sub = 1'b0; start = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (phase == 0 && done_v[0]) begin
        lat1 = n;
        check("t4_first_result", 64'(result_v[0]), 64'(32'd123));
        phase = 1; t1 = n;
        a = 32'd5; b = 32'd9; sub = 1'b1; start = 1'b1;
      end else if (phase == 1 && n == t1 + 1) begin
        check("t4_done_drop", 64'(done_v[0]), 64'(0));
        check("t4_busy_again", 64'(busy_v[0]), 64'(1));
        start = 1'b0;
      end else if (phase == 1 && done_v[0]) begin
        lat2 = n - t1 - 1;
        check("t4_second_result", 64'(result_v[0]), 64'(32'hFFFF_FFFC));
        check("t4_second_cout", 64'(cout_v[0]), 64'(0));
        phase = 2; start = 1'b0;
      end else if (phase == 0 && (n == 1 || n == 3)) begin
        start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("t4_first_latency", 64'(lat1), 64'(8));
    check("t4_second_latency", 64'(lat2), 64'(8));
    repeat (40) @(posedge clk);

    // reset in the middle of an operation
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; #1;
    check("t5_busy", 64'(busy_v[0]), 64'(0));
    check("t5_done", 64'(done_v[0]), 64'(0));
    check("t5_result", 64'(result_v[0]), 64'(0));
    check("t5_flags", 64'({cout_v[0], ovf_v[0], zero_v[0]}), 64'(0));
    @(negedge clk); @(negedge clk); rst = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0]) nd++;
    end
    check("t5_no_done_after_abort", 64'(nd), 64'(0));
    do_op("t5_after_reset", 32'd3, 32'd4, 1'b0, 1'b0, r, c, o, z);
    check("t5_result_7", 64'(r), 64'(32'd7));

    // randomized add/sub on all three digit sizes, inputs scrambled while busy
    for (int i = 0; i < 1000; i++) begin
      do_op($sformatf("rnd%0d", i), pick_operand(), pick_operand(), 1'($urandom), 1'b1, r, c, o, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
